// File: rtl/filter_stream_rx_if.sv
// -----------------------------------------------------------------------------
// filter_stream_rx_if
//
// Purpose: bundles the sample stream coming out of the filter together with
// the buffered output stream toward the downstream consumer.
//
// Signals:
//   s_tdata  [13:0] filter output sample, two's complement
//   s_tvalid        sample strobe (no backpressure toward the filter)
//   s_mode          filter mode tag (0 differentiator, 1 integrator)
//   m_tdata  [13:0] buffered sample
//   m_tuser  [1:0]  bit0 = mode, bit1 = start-of-frame
//   m_tlast         last sample of a frame
//   m_tvalid        output sample available
//   m_tready        downstream accept
//
// Modports:
//   slave  - the buffer itself (consumes s_*, produces m_*)
//   master - the environment (filter source plus downstream sink)
// -----------------------------------------------------------------------------
interface filter_stream_rx_if;
  logic signed [13:0] s_tdata;
  logic               s_tvalid;
  logic               s_mode;

  logic signed [13:0] m_tdata;
  logic [1:0]         m_tuser;
  logic               m_tlast;
  logic               m_tvalid;
  logic               m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_mode, m_tready,
    output m_tdata, m_tuser, m_tlast, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_mode, m_tready,
    input  m_tdata, m_tuser, m_tlast, m_tvalid
  );
endinterface

// File: rtl/filter_stream_rx.sv
// -----------------------------------------------------------------------------
// filter_stream_rx
//
// Purpose: receives a valid-only sample stream from a filter, tags each
// accepted sample with frame boundaries (start-of-frame / last) and the filter
// mode, buffers it in a DEPTH-entry circular FIFO and presents it on a
// ready/valid output stream through a registered output stage.
// When the FIFO overflows the block enters a DROP state and discards every
// incoming sample until the FIFO has fully drained; the first sample accepted
// afterwards opens a new frame.
//
// Parameters:
//   DEPTH      FIFO depth in samples (power of 2, 4..256)
//   FRAME_LEN  samples per frame before m_tlast (2..65535)
//
// Ports:
//   clk        rising-edge clock
//   srst_n     synchronous active-low reset
//   bus        filter_stream_rx_if.slave (s_* input stream, m_* output stream)
//   ovf_clr    one-cycle pulse clearing the sticky overflow flag
//   ovf        sticky overflow flag
//   smp_cnt    accepted-sample counter, saturating
//   drop_cnt   dropped-sample counter, saturating
//
// Build option:
//   FILTER_STREAM_RX_STATS_EN  when defined, smp_cnt/drop_cnt count; when
//                              undefined both are tied to zero.
// -----------------------------------------------------------------------------
module filter_stream_rx #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                     clk,
  input  logic                     srst_n,
  filter_stream_rx_if.slave        bus,
  input  logic                     ovf_clr,
  output logic                     ovf,
  output logic [31:0]              smp_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int DATA_W = 14;
  localparam int PTR_W  = $clog2(DEPTH);
  // Entry layout: {data, mode, sof, last}
  localparam int ENT_W  = DATA_W + 3;

  localparam logic [PTR_W:0] DEPTH_C     = (PTR_W+1)'(DEPTH);
  localparam logic [15:0]    FRAME_LEN_C = 16'(FRAME_LEN);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]          mem_q [DEPTH];

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]            count_q,  count_d;

  state_t                    state_q,  state_d;

  logic [15:0]               frm_cnt_q,   frm_cnt_d;
  logic                      prev_mode_q, prev_mode_d;
  logic                      ovf_q,       ovf_d;

  logic signed [DATA_W-1:0]  m_tdata_q,  m_tdata_d;
  logic [1:0]                m_tuser_q,  m_tuser_d;
  logic                      m_tlast_q,  m_tlast_d;
  logic                      m_tvalid_q, m_tvalid_d;

  // Per-cycle control
  logic                      full;
  logic                      pop;
  logic                      accept;
  logic                      ovf_evt;

  // Write-side entry construction
  logic                      restart;
  logic [15:0]               wr_cnt;
  logic                      wr_sof;
  logic                      wr_last;
  logic [ENT_W-1:0]          wr_entry;

  // Read-side prefetch
  logic [PTR_W:0]            avail;
  logic [PTR_W-1:0]          head_ptr;
  logic [ENT_W-1:0]          head_entry;

  assign full = (count_q == DEPTH_C);
  assign pop  = m_tvalid_q && bus.m_tready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (ovf_evt) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // Leave DROP on the edge that empties the FIFO, so the very next
        // cycle already accepts samples.
        if (count_d == '0) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (accept / overflow decisions)
  // ---------------------------------------------------------------------------
  always_comb begin
    accept  = 1'b0;
    ovf_evt = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // A full FIFO can still take a sample when the head leaves this cycle.
        accept  = bus.s_tvalid && (!full || pop);
        ovf_evt = bus.s_tvalid && full && !pop;
      end
      ST_DROP: begin
        accept  = 1'b0;
        ovf_evt = 1'b0;
      end
      default: begin
        accept  = 1'b0;
        ovf_evt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame tagging, pointers, occupancy, sticky overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    // A frame restarts after reset / DROP exit (counter 0), after a completed
    // frame, or when the filter mode changes. Entries already stored are never
    // touched, so a mode change cannot turn an earlier entry into a 'last'.
    restart  = (frm_cnt_q == 16'd0) || (frm_cnt_q == FRAME_LEN_C) ||
               (bus.s_mode != prev_mode_q);
    wr_cnt   = restart ? 16'd1 : (frm_cnt_q + 16'd1);
    wr_sof   = restart;
    wr_last  = (wr_cnt == FRAME_LEN_C);
    wr_entry = {bus.s_tdata, bus.s_mode, wr_sof, wr_last};

    frm_cnt_d   = frm_cnt_q;
    prev_mode_d = prev_mode_q;
    if (accept) begin
      frm_cnt_d   = wr_cnt;
      prev_mode_d = bus.s_mode;
    end else if ((state_q == ST_DROP) && (state_d == ST_RUN)) begin
      frm_cnt_d = 16'd0;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};

    // Set wins over clear so a coincident overflow is not lost.
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: registered copy of the FIFO head
  // ---------------------------------------------------------------------------
  always_comb begin
    // Only entries written before this edge are eligible, which gives the
    // one-cycle write-to-output latency. The head stays in the FIFO (and in
    // the occupancy count) until it is actually transferred.
    avail      = count_q - {{PTR_W{1'b0}}, pop};
    head_ptr   = rd_ptr_q + PTR_W'(pop);
    head_entry = mem_q[head_ptr];

    m_tvalid_d = (avail != '0);
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    if (avail != '0) begin
      m_tdata_d = $signed(head_entry[ENT_W-1:3]);
      m_tuser_d = {head_entry[1], head_entry[2]};
      m_tlast_d = head_entry[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frm_cnt_q   <= 16'd0;
      prev_mode_q <= 1'b0;
      ovf_q       <= 1'b0;
      m_tdata_q   <= '0;
      m_tuser_q   <= 2'b00;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frm_cnt_q   <= frm_cnt_d;
      prev_mode_q <= prev_mode_d;
      ovf_q       <= ovf_d;
      m_tdata_q   <= m_tdata_d;
      m_tuser_q   <= m_tuser_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
    end
  end

  // Sample storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign ovf          = ovf_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef FILTER_STREAM_RX_STATS_EN
  logic        drop;
  logic [31:0] smp_cnt_q,  smp_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : (v + 32'd1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : (v + 16'd1);
  endfunction

  // Every strobe not accepted is a drop, in RUN (overflow) and in DROP.
  assign drop = bus.s_tvalid && !accept;

  always_comb begin
    smp_cnt_d  = accept ? sat_inc32(smp_cnt_q)  : smp_cnt_q;
    drop_cnt_d = drop   ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      smp_cnt_q  <= 32'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      smp_cnt_q  <= smp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign smp_cnt  = smp_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign smp_cnt  = 32'd0;
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_filter_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_filter_stream_rx
//
// Bench for filter_stream_rx (DEPTH=16, FRAME_LEN=4). A behavioural model
// keeps the stored samples in a queue, each stamped with the edge it was
// written on, and derives every expected output from that queue after each
// rising edge. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_filter_stream_rx;

  localparam int DEPTH     = 16;
  localparam int FRAME_LEN = 4;
`ifdef FILTER_STREAM_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        srst_n;
  logic        ovf_clr;
  logic        ovf;
  logic [31:0] smp_cnt;
  logic [15:0] drop_cnt;

  filter_stream_rx_if sif ();

  filter_stream_rx #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk      (clk),
    .srst_n   (srst_n),
    .bus      (sif),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .smp_cnt  (smp_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [13:0] data;
    bit          mode;
    bit          sof;
    bit          last;
    int          t;      // edge index on which the sample was written
  } ent_t;

  ent_t        mq[$];
  int          cyc     = 0;
  bit          m_run   = 1'b1;
  int          m_fcnt  = 0;
  bit          m_prev  = 1'b0;
  bit          m_ovf   = 1'b0;
  longint      m_smp   = 0;
  longint      m_drop  = 0;
  bit          m_rst   = 1'b1;

  task automatic model_edge();
    bit   pop, full, acc, oev, restart;
    ent_t e;
    cyc++;
    if (!srst_n) begin
      mq.delete();
      m_run  = 1'b1;
      m_fcnt = 0;
      m_prev = 1'b0;
      m_ovf  = 1'b0;
      m_smp  = 0;
      m_drop = 0;
      m_rst  = 1'b1;
      return;
    end
    m_rst = 1'b0;
    // A sample is presented from the second edge after its write onward.
    pop  = (mq.size() > 0) && (mq[0].t < cyc - 1) && sif.m_tready;
    full = (mq.size() == DEPTH);
    acc  = 1'b0;
    oev  = 1'b0;
    if (sif.s_tvalid) begin
      if (m_run && (!full || pop)) acc = 1'b1;
      else begin
        if (m_run) oev = 1'b1;
        if (m_drop < 64'hFFFF) m_drop++;
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      restart = (m_fcnt == 0) || (m_fcnt == FRAME_LEN) || (sif.s_mode != m_prev);
      m_fcnt  = restart ? 1 : m_fcnt + 1;
      e.data  = sif.s_tdata;
      e.mode  = sif.s_mode;
      e.sof   = restart;
      e.last  = (m_fcnt == FRAME_LEN);
      e.t     = cyc;
      mq.push_back(e);
      m_prev  = sif.s_mode;
      if (m_smp < 64'hFFFF_FFFF) m_smp++;
    end
    if (ovf_clr) m_ovf = 1'b0;
    if (oev)     m_ovf = 1'b1;
    if (oev) m_run = 1'b0;
    else if (!m_run && mq.size() == 0) begin
      m_run  = 1'b1;
      m_fcnt = 0;
    end
  endtask

  task automatic compare_outputs();
    bit exp_v;
    exp_v = (mq.size() > 0) && (mq[0].t < cyc);
    check_eq("m_tvalid", {31'd0, sif.m_tvalid}, {31'd0, exp_v});
    if (exp_v) begin
      check_eq("m_tdata", {18'd0, sif.m_tdata}, {18'd0, mq[0].data});
      check_eq("m_tuser", {30'd0, sif.m_tuser}, {30'd0, mq[0].sof, mq[0].mode});
      check_eq("m_tlast", {31'd0, sif.m_tlast}, {31'd0, mq[0].last});
    end else if (m_rst) begin
      check_eq("rst_m_tdata", {18'd0, sif.m_tdata}, 32'd0);
      check_eq("rst_m_tuser", {30'd0, sif.m_tuser}, 32'd0);
      check_eq("rst_m_tlast", {31'd0, sif.m_tlast}, 32'd0);
    end
    check_eq("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check_eq("smp_cnt", smp_cnt, STATS ? 32'(m_smp) : 32'd0);
    check_eq("drop_cnt", {16'd0, drop_cnt}, STATS ? 32'(m_drop) : 32'd0);
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    compare_outputs();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input bit tv, input bit md, input logic [13:0] dt, input bit rdy);
    sif.s_tvalid = tv;
    sif.s_mode   = md;
    sif.s_tdata  = dt;
    sif.m_tready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    drive(1'b0, 1'b0, 14'd0, 1'b1);
    srst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!sif.m_tvalid) break;
      drive(1'b0, 1'b0, 14'd0, 1'b1);
    end
    check_eq(tag, {31'd0, sif.m_tvalid}, 32'd0);
  endtask

  task automatic wait_head(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (sif.m_tvalid) break;
      drive(1'b0, 1'b0, 14'd0, 1'b0);
    end
    check_eq(tag, {31'd0, sif.m_tvalid}, 32'd1);
  endtask

  initial begin
    srst_n       = 1'b0;
    ovf_clr      = 1'b0;
    sif.s_tvalid = 1'b0;
    sif.s_mode   = 1'b0;
    sif.s_tdata  = '0;
    sif.m_tready = 1'b0;
    repeat (2) @(negedge clk);
    srst_n = 1'b1;

    // Five in-order samples, one-cycle latency, first tagged start-of-frame.
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 14'(i), 1'b1);
    drain("s1_drain");

    // Nine continuous samples: frames of four.
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 14'(16'h100 + i), 1'b1);
    drain("s2_drain");

    // Mode change restarts the frame.
    do_reset();
    drive(1'b1, 1'b0, 14'h0011, 1'b1);
    drive(1'b1, 1'b0, 14'h0012, 1'b1);
    drive(1'b1, 1'b1, 14'h3FF3, 1'b1);
    drive(1'b1, 1'b1, 14'h2004, 1'b1);
    drain("s3_drain");

    // Overflow into DROP, drain, resume with a new frame.
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 14'(i + 32), 1'b0);
    check_eq("s4_ovf_set", {31'd0, ovf}, 32'd1);
    check_eq("s4_drop4", {16'd0, drop_cnt}, STATS ? 32'd4 : 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 14'h0AAA, 1'b1);
    check_eq("s4_drop7", {16'd0, drop_cnt}, STATS ? 32'd7 : 32'd0);
    drain("s4_drain");
    drive(1'b1, 1'b0, 14'h0155, 1'b0);
    wait_head("s4_resume_valid");
    check_eq("s4_resume_sof", {30'd0, sif.m_tuser}, 32'd2);
    ovf_clr = 1'b1;
    drive(1'b0, 1'b0, 14'd0, 1'b1);
    ovf_clr = 1'b0;
    check_eq("s4_ovf_clr", {31'd0, ovf}, 32'd0);
    drain("s4_drain2");

    // Full FIFO with a read and a write in the same cycle.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 14'(i + 200), 1'b0);
    check_eq("s5_full_no_ovf", {31'd0, ovf}, 32'd0);
    drive(1'b1, 1'b0, 14'h1234, 1'b1);
    check_eq("s5_rw_no_ovf", {31'd0, ovf}, 32'd0);
    // Still full: this one overflows while ovf_clr is pulsed.
    ovf_clr = 1'b1;
    drive(1'b1, 1'b0, 14'h0BAD, 1'b0);
    ovf_clr = 1'b0;
    check_eq("s5_clr_vs_set", {31'd0, ovf}, 32'd1);
    drain("s5_drain");

    // Reset with entries stored.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 14'(i + 300), 1'b0);
    do_reset();
    check_eq("s6_valid_low", {31'd0, sif.m_tvalid}, 32'd0);
    check_eq("s6_ovf_low", {31'd0, ovf}, 32'd0);
    check_eq("s6_smp_zero", smp_cnt, 32'd0);
    check_eq("s6_drop_zero", {16'd0, drop_cnt}, 32'd0);
    drive(1'b1, 1'b1, 14'h0077, 1'b0);
    wait_head("s6_next_valid");
    check_eq("s6_next_sof", {30'd0, sif.m_tuser}, 32'd3);
    drain("s6_drain");

    // Randomized traffic.
    begin
      bit md;
      md = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(99) < 10) md = ~md;
        ovf_clr = ($urandom_range(99) < 3);
        srst_n  = !($urandom_range(999) < 4);
        drive($urandom_range(99) < 60, md, 14'($urandom), $urandom_range(99) < 45);
        ovf_clr = 1'b0;
        srst_n  = 1'b1;
      end
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
